// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; results land WIDTH+1 cycles after start is accepted.
// No input backpressure: requests (including MTHI/MTLO) arriving while busy are dropped; abort cancels the operation.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic [OPW-1:0]   opSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [OPW-1:0] OP_MULT  = OPW'(0);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(1);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(2);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(3);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(4);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(5);

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Request decode: signed ops iterate on magnitudes and fix signs at the end.
  logic             req_mul, req_div, req_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign req_mul    = (opSel == OP_MULT) || (opSel == OP_MULTU);
  assign req_div    = (opSel == OP_DIV)  || (opSel == OP_DIVU);
  assign req_signed = (opSel == OP_MULT) || (opSel == OP_DIV);
  assign a_mag      = (req_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag      = (req_signed && B[WIDTH-1]) ? -B : B;

  // One shift-add step: multiplier sits in acc_lo and is shifted out as the product shifts in.
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  assign add_sum    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
  assign mul_hi_nxt = add_sum[WIDTH:1];
  assign mul_lo_nxt = {add_sum[0], acc_lo_q[WIDTH-1:1]};

  // One restoring step: dividend shifts out of acc_lo into the partial remainder, quotient bits shift in.
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;
  assign rem_sh     = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_diff   = rem_sh - {1'b0, opb_q};
  assign div_hi_nxt = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
  assign div_lo_nxt = {acc_lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};

  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod     = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
  assign quo      = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
  assign rem      = neg_a_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    res_hi = rem;
    res_lo = quo;
    if (is_mul_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_zero_q) begin
      res_hi = a_q;
      res_lo = {WIDTH{1'b1}};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    a_d      = a_q;
    opb_d    = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (req_mul || req_div) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_mul_d = req_mul;
            neg_a_d  = req_signed && A[WIDTH-1];
            neg_b_d  = req_signed && B[WIDTH-1];
            b_zero_d = (B == '0);
            a_d      = A;
            opb_d    = req_mul ? a_mag : b_mag;
            acc_hi_d = '0;
            acc_lo_d = req_mul ? b_mag : a_mag;
          end else if (opSel == OP_MTHI) begin
            hi_d = A;
          end else if (opSel == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = is_mul_q ? mul_hi_nxt : div_hi_nxt;
          acc_lo_d = is_mul_q ? mul_lo_nxt : div_lo_nxt;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!abort) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      a_q      <= a_d;
      opb_q    <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: fixed vector table, randomized ops against an arithmetic model, and abort/reset/ignore sequences.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   opSel = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t        vt [12];
  logic [31:0] sv_hi, sv_lo, m_hi, m_lo, ra, rb;
  logic [2:0]  rop;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W), .OPW(3)) dut (
    .clock (clock),
    .resetN(resetN),
    .start (start),
    .opSel (opSel),
    .A     (A),
    .B     (B),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o_hi, output logic [31:0] o_lo);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
      default: p = '0;
    endcase
    o_hi = p[63:32];
    o_lo = p[31:0];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with inputs scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    opSel = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    opSel = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int pre, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int n;
    n = pre;
    while (busy && n < 200) begin
      check({name, " done while busy"}, done, 0);
      n++;
      @(negedge clock);
    end
    check({name, " busy cycles"}, n, W + 1);
    check({name, " done"}, done, 1);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[4]  = '{3'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
    vt[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[6]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[7]  = '{3'd3, 32'd100,       32'd7,        32'd2,         32'd14};
    vt[8]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vt[9]  = '{3'd0, 32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000};
    vt[10] = '{3'd1, 32'd3,         32'd5,        32'd0,         32'd15};
    vt[11] = '{3'd1, 32'h8000_0000, 32'd2,        32'd1,         32'd0};

    repeat (2) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    resetN = 1'b1;
    @(negedge clock);

    // Table vectors, each accepted in the done cycle of the previous one.
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_done(0, vt[i].exp_hi, vt[i].exp_lo, $sformatf("vec%0d", i));
    end
    @(negedge clock);
    check("done single pulse", done, 0);

    // MTHI / MTLO while idle.
    sv_lo = lo;
    opSel = 3'd4; A = 32'h1234; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi lo kept", lo, sv_lo);
    check("mthi busy", busy, 0);
    check("mthi done", done, 0);
    opSel = 3'd5; A = 32'h5678; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("mtlo lo", lo, 32'h5678);
    check("mtlo hi kept", hi, 32'h1234);

    // No-op opcodes and abort-in-idle suppress start.
    for (int k = 6; k < 8; k++) begin
      opSel = 3'(k); A = 32'hDEAD_BEEF; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check($sformatf("noop%0d busy", k), busy, 0);
      check($sformatf("noop%0d hi", k), hi, 32'h1234);
      check($sformatf("noop%0d lo", k), lo, 32'h5678);
    end
    opSel = 3'd0; A = 32'd9; B = 32'd9; start = 1'b1; abort = 1'b1;
    @(negedge clock);
    check("idle abort busy", busy, 0);
    opSel = 3'd4;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check("idle abort mthi", hi, 32'h1234);

    // Requests while busy are dropped, MTLO included.
    model(3'd2, 32'hFFFF_FC18, 32'd7, m_hi, m_lo);
    issue(3'd2, 32'hFFFF_FC18, 32'd7);
    repeat (5) @(negedge clock);
    opSel = 3'd1; A = 32'd11; B = 32'd13; start = 1'b1;
    @(negedge clock);
    opSel = 3'd5; A = 32'hDEAD;
    @(negedge clock);
    start = 1'b0;
    wait_done(7, m_hi, m_lo, "ignore-busy");

    // Abort during RUN.
    sv_hi = hi; sv_lo = lo;
    issue(3'd1, 32'h0001_0001, 32'h0000_FFFF);
    repeat (9) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort run busy", busy, 0);
    check("abort run done", done, 0);
    repeat (3) @(negedge clock);
    check("abort run done later", done, 0);
    check("abort run hi", hi, sv_hi);
    check("abort run lo", lo, sv_lo);

    // Abort in the FINISH cycle.
    issue(3'd3, 32'd1000, 32'd3);
    repeat (32) @(negedge clock);
    check("finish busy", busy, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort fin busy", busy, 0);
    check("abort fin done", done, 0);
    check("abort fin hi", hi, sv_hi);
    check("abort fin lo", lo, sv_lo);

    // Randomized back-to-back ops against the model.
    for (int i = 0; i < 25; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
        3: rb = $urandom_range(1, 100);
        default: ;
      endcase
      model(rop, ra, rb, m_hi, m_lo);
      issue(rop, ra, rb);
      wait_done(0, m_hi, m_lo, $sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb));
    end

    // Asynchronous reset mid-multiply.
    opSel = 3'd4; A = 32'hABCD; start = 1'b1;
    @(negedge clock);
    opSel = 3'd5; A = 32'h1357;
    @(negedge clock);
    start = 1'b0;
    issue(3'd0, 32'd123, 32'hFFFF_FFFC);
    repeat (11) @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst hi", hi, 0);
    check("async rst lo", lo, 0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    issue(3'd1, 32'd3, 32'd5);
    wait_done(0, 32'd0, 32'd15, "post-reset multu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
